// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and RAW/WAW hazard scoreboard in front of a 32x32 register file.
// Optional sticky writeback error flag (wb_err) when RFSCHED_ERR_EN is defined.

module regfile_wb_busy_cell (
   input  logic C,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic busy
);
   // set wins: a new issue to a register overrides a stray commit to it
   always_ff @(posedge C or posedge rst) begin
      if (rst)      busy <= 1'b0;
      else if (set) busy <= 1'b1;
      else if (clr) busy <= 1'b0;
   end
endmodule

module regfile_wb_sched #(
   parameter int MAX_PENDING = 4,
   parameter int FIXED_PRIO  = 0
) (
   input  logic        C,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_ra,
   input  logic [4:0]  issue_rb,
   output logic        issue_ready,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rw,
   output logic [31:0] rf_din,
`ifdef RFSCHED_ERR_EN
   output logic        wb_err,
`endif
   output logic [31:0] busy_mask,
   output logic [4:0]  pend_cnt
);
   localparam int         STAGES = 1;
   localparam logic [4:0] MAXP   = 5'(MAX_PENDING);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   logic [31:0]     busy;
   logic [31:0]     set_vec, clr_vec;
   logic [4:0]      cnt;
   logic            rr_lsu;          // 1: LSU won the most recent contention
   logic            both, pick_lsu, gnt;
   logic            accept, commit;
   wb_req_t         gnt_req;
   logic [STAGES:0] vld_pipe;

   assign both = alu_valid & lsu_valid;

   always_comb begin
      pick_lsu = lsu_valid;
      if (both) pick_lsu = (FIXED_PRIO != 0) ? 1'b1 : !rr_lsu;
   end

   // handshakes are held low during reset so nothing is accepted while state is cleared
   assign alu_ready   = !rst & alu_valid & !pick_lsu;
   assign lsu_ready   = !rst & lsu_valid &  pick_lsu;
   assign gnt         = alu_ready | lsu_ready;
   assign gnt_req     = lsu_ready ? wb_req_t'{lsu_rd, lsu_data} : wb_req_t'{alu_rd, alu_data};

   assign issue_ready = !rst & !busy[issue_ra] & !busy[issue_rb] & !busy[issue_rd]
                        & (cnt < MAXP);
   assign accept      = issue_valid & issue_ready & (issue_rd != 5'd0);
   assign commit      = rf_we & busy[rf_rw];

   assign set_vec = accept ? (32'd1 << issue_rd) : 32'd0;
   assign clr_vec = commit ? (32'd1 << rf_rw)    : 32'd0;

   assign busy[0] = 1'b0;
   for (genvar n = 1; n < 32; n++) begin : g_busy
      regfile_wb_busy_cell u_cell (
         .C    (C),
         .rst  (rst),
         .set  (set_vec[n]),
         .clr  (clr_vec[n]),
         .busy (busy[n])
      );
   end

   always_ff @(posedge C or posedge rst) begin
      if (rst) begin
         cnt <= 5'd0;
      end else begin
         case ({accept, commit})
            2'b10:   if (cnt < MAXP)   cnt <= cnt + 5'd1;
            2'b01:   if (cnt != 5'd0)  cnt <= cnt - 5'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // one-stage write pipe: stage 0 is the live grant, stage 1 drives the port
   assign vld_pipe[0] = gnt & (gnt_req.rd != 5'd0);

   always_ff @(posedge C or posedge rst) begin
      if (rst) begin
         vld_pipe[STAGES:1] <= '0;
         rf_rw              <= 5'd0;
         rf_din             <= 32'd0;
         rr_lsu             <= 1'b1;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (gnt) begin
            rf_rw  <= gnt_req.rd;
            rf_din <= gnt_req.data;
         end
         if (both) rr_lsu <= pick_lsu;
      end
   end

   assign rf_we     = vld_pipe[STAGES];
   assign busy_mask = busy;
   assign pend_cnt  = cnt;

`ifdef RFSCHED_ERR_EN
   logic err_set;
   assign err_set = (gnt & (gnt_req.rd != 5'd0) & !busy[gnt_req.rd])
                  | (both & (alu_rd == lsu_rd) & (alu_rd != 5'd0));

   always_ff @(posedge C or posedge rst) begin
      if (rst)          wb_err <= 1'b0;
      else if (err_set) wb_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: round-robin DUT plus a fixed-priority twin on shared inputs.
// A behavioural register file model closes the loop for read-after-writeback checks.

module tb_regfile_wb_sched;
   logic        C = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_ra, issue_rb;
   logic        alu_valid, lsu_valid;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;

   logic        issue_ready, alu_ready, lsu_ready, rf_we;
   logic [4:0]  rf_rw, pend_cnt;
   logic [31:0] rf_din, busy_mask;
   logic        f_issue_ready, f_alu_ready, f_lsu_ready, f_rf_we;
   logic [4:0]  f_rf_rw, f_pend_cnt;
   logic [31:0] f_rf_din, f_busy_mask;
`ifdef RFSCHED_ERR_EN
   logic        wb_err, f_wb_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   regfile_wb_sched #(.MAX_PENDING(4), .FIXED_PRIO(0)) u_dut (
      .C(C), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ra(issue_ra), .issue_rb(issue_rb),
      .issue_ready(issue_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_we(rf_we), .rf_rw(rf_rw), .rf_din(rf_din),
`ifdef RFSCHED_ERR_EN
      .wb_err(wb_err),
`endif
      .busy_mask(busy_mask), .pend_cnt(pend_cnt)
   );

   regfile_wb_sched #(.MAX_PENDING(4), .FIXED_PRIO(1)) u_fp (
      .C(C), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ra(issue_ra), .issue_rb(issue_rb),
      .issue_ready(f_issue_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(f_alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(f_lsu_ready),
      .rf_we(f_rf_we), .rf_rw(f_rf_rw), .rf_din(f_rf_din),
`ifdef RFSCHED_ERR_EN
      .wb_err(f_wb_err),
`endif
      .busy_mask(f_busy_mask), .pend_cnt(f_pend_cnt)
   );

   always #5 C = ~C;

   // register file fed by the round-robin DUT's write port
   logic [31:0] rf_mem [32];
   always @(posedge C) if (rf_we) rf_mem[rf_rw] <= rf_din;

   function automatic logic [31:0] rd_a(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : rf_mem[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge C);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
      rst = 1'b1;
      issue_valid = 0; issue_rd = 0; issue_ra = 0; issue_rb = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_busy", busy_mask, 32'd0);
      chk("rst_pend", 32'(pend_cnt), 32'd0);
      chk("rst_we",   32'(rf_we), 32'd0);
      chk("rst_rw",   32'(rf_rw), 32'd0);
      chk("rst_din",  rf_din, 32'd0);

      // RAW stall released by ALU writeback
      issue_valid = 1; issue_rd = 5; issue_ra = 1; issue_rb = 2;
      #1 chk("iss5_rdy", 32'(issue_ready), 32'd1);
      step();
      issue_valid = 0;
      chk("iss5_busy", busy_mask, 32'h20);
      chk("iss5_pend", 32'(pend_cnt), 32'd1);
      issue_valid = 1; issue_rd = 7; issue_ra = 5; issue_rb = 0;
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      #1;
      chk("raw_stall", 32'(issue_ready), 32'd0);
      chk("alu_gnt",   32'(alu_ready), 32'd1);
      step();
      alu_valid = 0;
      chk("wb_we",    32'(rf_we), 32'd1);
      chk("wb_rw",    32'(rf_rw), 32'd5);
      chk("wb_din",   rf_din, 32'hDEADBEEF);
      chk("raw_hold", 32'(issue_ready), 32'd0);
      chk("wb_busy",  busy_mask, 32'h20);
      step();
      chk("clr_busy", busy_mask, 32'd0);
      chk("clr_pend", 32'(pend_cnt), 32'd0);
      chk("clr_we",   32'(rf_we), 32'd0);
      chk("raw_rdy",  32'(issue_ready), 32'd1);
      chk("raw_da",   rd_a(issue_ra), 32'hDEADBEEF);
      issue_valid = 0;

      // contention: round-robin alternates, fixed-priority twin always picks LSU
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr_alu%0d", i), 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr_lsu%0d", i), 32'(lsu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         chk($sformatf("fp_lsu%0d", i), 32'(f_lsu_ready), 32'd1);
         chk($sformatf("fp_alu%0d", i), 32'(f_alu_ready), 32'd0);
         step();
         chk($sformatf("rr_rw%0d", i),  32'(rf_rw), (i % 2 == 0) ? 32'd3 : 32'd4);
         chk($sformatf("rr_din%0d", i), rf_din, (i % 2 == 0) ? 32'h11 : 32'h22);
         chk($sformatf("fp_rw%0d", i),  32'(f_rf_rw), 32'd4);
      end
      lsu_valid = 0;
      #1 chk("fp_alu_late", 32'(f_alu_ready), 32'd1);
      step();
      chk("fp_alu_rw", 32'(f_rf_rw), 32'd3);
      alu_valid = 0;
      step();
      chk("nb_busy", busy_mask, 32'd0);
      chk("nb_pend", 32'(pend_cnt), 32'd0);

      // MAX_PENDING limit
      for (int r = 1; r <= 4; r++) begin
         issue_valid = 1; issue_rd = 5'(r); issue_ra = 0; issue_rb = 0;
         #1 chk($sformatf("fill_rdy%0d", r), 32'(issue_ready), 32'd1);
         step();
      end
      issue_rd = 6;
      #1;
      chk("full_pend", 32'(pend_cnt), 32'd4);
      chk("full_busy", busy_mask, 32'h1E);
      chk("full_rdy",  32'(issue_ready), 32'd0);
      alu_valid = 1; alu_rd = 2; alu_data = 32'h55;
      step();
      alu_valid = 0;
      chk("full_hold", 32'(issue_ready), 32'd0);
      step();
      chk("drain_pend", 32'(pend_cnt), 32'd3);
      chk("drain_rdy",  32'(issue_ready), 32'd1);
      step();
      issue_valid = 0;
      chk("acc6_pend", 32'(pend_cnt), 32'd4);
      chk("acc6_busy", busy_mask, 32'h5A);
      for (int r = 1; r <= 6; r++) begin
         if (r == 2 || r == 5) continue;
         alu_valid = 1; alu_rd = 5'(r); alu_data = 32'(r);
         step();
      end
      alu_valid = 0;
      step();
      chk("empty_pend", 32'(pend_cnt), 32'd0);
      chk("empty_busy", busy_mask, 32'd0);

      // x0 never tracked or written
      issue_valid = 1; issue_rd = 0; issue_ra = 0; issue_rb = 0;
      #1 chk("x0_rdy", 32'(issue_ready), 32'd1);
      step();
      issue_valid = 0;
      chk("x0_busy", busy_mask, 32'd0);
      chk("x0_pend", 32'(pend_cnt), 32'd0);
      alu_valid = 1; alu_rd = 0; alu_data = 32'h99;
      #1 chk("x0_gnt", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 0;
      chk("x0_we",    32'(rf_we), 32'd0);
      chk("x0_busy2", busy_mask, 32'd0);
      chk("x0_pend2", 32'(pend_cnt), 32'd0);

`ifdef RFSCHED_ERR_EN
      chk("err_idle", 32'(wb_err), 32'd0);
      alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
      step();
      alu_valid = 0;
      chk("err_set", 32'(wb_err), 32'd1);
      step(); step();
      chk("err_sticky", 32'(wb_err), 32'd1);
`endif

      // async reset in the middle of a write
      issue_valid = 1; issue_rd = 7; issue_ra = 0; issue_rb = 0;
      step();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 7; alu_data = 32'hA5A5;
      lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h77;
      #1 chk("pre_alu", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 0;
      chk("mid_we",   32'(rf_we), 32'd1);
      chk("mid_busy", busy_mask, 32'h80);
      rst = 1'b1;
      #1;
      chk("ar_we",   32'(rf_we), 32'd0);
      chk("ar_rw",   32'(rf_rw), 32'd0);
      chk("ar_din",  rf_din, 32'd0);
      chk("ar_busy", busy_mask, 32'd0);
      chk("ar_pend", 32'(pend_cnt), 32'd0);
      chk("ar_lsu",  32'(lsu_ready), 32'd0);
`ifdef RFSCHED_ERR_EN
      chk("ar_err",  32'(wb_err), 32'd0);
`endif
      rst = 1'b0;
      alu_valid = 1;
      #1 chk("ar_rr_alu", 32'(alu_ready), 32'd1);
      alu_valid = 0; lsu_valid = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
